vpf_cluster_serializer: RTL

Reader-side partner of the cluster counter. It snapshots one frame of valid-pattern flags together with the frame's cluster count. It then drains up to MXCLUSTERS cluster addresses, lowest index first, one per accepted handshake, using a priority-encode-and-clear loop. It flags overflow when the count exceeds the readout budget, and flags count/flag disagreement.

---
 rtl/vpf_cluster_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vpf_cluster_serializer.sv
// Snapshots one frame of valid-pattern flags and its cluster count, then drains
// up to MXCLUSTERS cluster addresses lowest-first over a valid/ready handshake.
module vpf_cluster_serializer #(
  parameter int NBITS      = 1536,
  parameter int ADRB       = 11,
  parameter int CNTB       = 8,
  parameter int MXCLUSTERS = 8
) (
  input  logic             clock4x,
  input  logic             reset,
  input  logic [NBITS-1:0] vpfs_in,
  input  logic [CNTB-1:0]  cnt_in,
  input  logic             load,
  output logic             busy,
  output logic [ADRB-1:0]  clust_adr,
  output logic             clust_vld,
  input  logic             clust_rdy,
  output logic             last,
  output logic             done,
  output logic             overflow,
  output logic             cnt_mismatch
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shadow_q, shadow_d, shadow_clr;
  logic [CNTB-1:0]  emitted_q, emitted_d;
  logic [CNTB-1:0]  budget_q, budget_d, load_budget, emitted_inc;
  logic             overflow_q, overflow_d;
  logic             mismatch_q, mismatch_d;
  logic [ADRB-1:0]  low_adr;
  logic             shadow_nz, single_bit, vld, is_last, handshake;

  // Scanning downward leaves the lowest set index as the final assignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    low_adr = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (shadow_q[i]) low_adr = ADRB'(i);
    end
  end

  always_comb begin
    shadow_clr          = shadow_q;
    shadow_clr[low_adr] = 1'b0;
  end

  assign shadow_nz   = |shadow_q;
  assign single_bit  = shadow_nz && (shadow_clr == '0);
  assign emitted_inc = emitted_q + CNTB'(1);
  assign load_budget = (cnt_in > CNTB'(MXCLUSTERS)) ? CNTB'(MXCLUSTERS) : cnt_in;

  assign vld       = (state_q == SCAN) && shadow_nz && (emitted_q < budget_q);
  assign is_last   = vld && ((emitted_q == budget_q - CNTB'(1)) || single_bit);
  assign handshake = vld && clust_rdy;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    emitted_d  = emitted_q;
    budget_d   = budget_q;
    overflow_d = overflow_q;
    mismatch_d = mismatch_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shadow_d   = vpfs_in;
          budget_d   = load_budget;
          emitted_d  = '0;
          overflow_d = cnt_in > CNTB'(MXCLUSTERS);
          mismatch_d = 1'b0;
          state_d    = (load_budget == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (handshake) begin
          shadow_d  = shadow_clr;
          emitted_d = emitted_inc;
          if (is_last) begin
            state_d = DONE;
            // Leftover flags without overflow: count too low; flags ran out early: count too high.
            if (((shadow_clr != '0) && !overflow_q) ||
                ((shadow_clr == '0) && (emitted_inc < budget_q)))
              mismatch_d = 1'b1;
          end
        end else if (!shadow_nz && (emitted_q < budget_q)) begin
          mismatch_d = 1'b1;
          state_d    = DONE;
        end else if (emitted_q >= budget_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock4x) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      emitted_q  <= '0;
      budget_q   <= '0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      emitted_q  <= emitted_d;
      budget_q   <= budget_d;
      overflow_q <= overflow_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign clust_adr    = low_adr;
  assign clust_vld    = vld;
  assign last         = is_last;
  assign overflow     = overflow_q;
  assign cnt_mismatch = mismatch_q;

endmodule
